multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the RV32I subset CPU. Sequences the fetch stage
//  (PC_Write, IR_Write), register file, ALU and data memory over IF/ID/EX/MEM/WB.
//  Decodes opcode/funct fields from the IR. Stalls on a data-memory ready handshake.
//  Sits beside the fetch stage; its PC_Write/IR_Write drive that stage directly.
// PARAMETERS
//  S_W        3   width of state encoding (state_o port)
// PORTS
//  clk_im     in   1  system clock; all state changes on rising edge
//  rst_n      in   1  reset, synchronous, active-low
//  run        in   1  1 = execute instructions; 0 = park in IDLE at next boundary
//  opcode     in   7  IR[6:0]
//  funct3     in   3  IR[14:12]
//  funct7_5   in   1  IR[30]
//  zf         in   1  ALU zero flag, valid combinationally in EX
//  mem_ready  in   1  data memory done (read data valid / write committed)
//  PC_Write   out  1  load PC from source PC_s
//  PC_s       out  2  0=PC+4, 1=branch target, 2=JAL target
//  IR_Write   out  1  load IR from instruction ROM
//  Reg_Write  out  1  register file write enable
//  w_data_s   out  2  rd source: 0=ALU, 1=mem data, 2=imm (LUI), 3=PC (JAL link)
//  rs2_imm_s  out  1  ALU B operand: 0=rs2, 1=immediate
//  ALU_OP     out  4  ALU function code
//  Mem_Read   out  1  data memory read request
//  Mem_Write  out  1  data memory write request
//  halted     out  1  1 in HALT state
//  state_o    out  S_W current state, debug
// BEHAVIOUR
//  - States: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6. Reset -> IDLE; every
//    output 0 in IDLE (including PC_s, w_data_s, ALU_OP).
//  - Class register (R, IALU, LOAD, STORE, BRANCH, LUI, JAL, ILL) latched in ID from opcode
//    (0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 1101111, other).
//    Cleared to ILL on reset.
//  - IDLE: run=1 -> IF, else stay.
//  - IF: IR_Write=1, PC_Write=1, PC_s=0 -> ID.
//  - ID: ILL -> HALT; LUI, JAL -> WB; else -> EX.
//  - EX: R/IALU -> WB. LOAD/STORE -> MEM, ALU_OP=ADD, rs2_imm_s=1.
//    BRANCH: ALU_OP=SUB. PC_Write = funct3[0] ^ zf (BEQ/BNE), PC_s=1.
//    Next state is IF if run, else IDLE. This is the only Mealy output.
//  - MEM: Mem_Read (LOAD) or Mem_Write (STORE) held high until mem_ready=1.
//    On mem_ready: LOAD -> WB. STORE -> IF if run, else IDLE.
//  - WB: Reg_Write=1; w_data_s per class (R/IALU 0, LOAD 1, LUI 2, JAL 3).
//    JAL also PC_Write=1, PC_s=2. Next state is IF if run, else IDLE.
//  - HALT: absorbing; halted=1, all other outputs 0; left only by reset.
//  - ALU_OP: R={funct7_5,funct3}; IALU={funct3==3'b101 ? funct7_5 : 0, funct3};
//    ADD=4'b0000; SUB=4'b1000.
//  - rs2_imm_s=1 in EX/MEM for IALU, LOAD, STORE; 0 otherwise.
//  - Latency, IF to next IF (cycles): R/IALU 4, LUI/JAL 3, BRANCH 3,
//    LOAD 5+wait, STORE 4+wait, where wait = cycles in MEM with mem_ready=0.
//  - run is sampled only at instruction boundaries (IDLE, and the exits of
//    EX-branch/MEM-store/WB). Dropping run mid-instruction completes that instruction.
//  - rst_n=0 at any clock edge, in any state (e.g. mid-MEM stall), forces IDLE next cycle.
//    Pending Mem_Read/Mem_Write drop to 0 that cycle.
//  - mem_ready outside MEM is ignored. opcode/funct are assumed stable from ID onward.
// TESTING
//  1 rst_n=0 two cycles, run=0 -> state_o=0, all outputs 0; run=1 -> IF, IR_Write=PC_Write=1.
//  2 R-type add (0x00208033), run=1 -> states 1,2,3,5,1.
//    ALU_OP=0000 in EX; Reg_Write=1, w_data_s=0 in WB.
//  3 LOAD, mem_ready low 2 cycles in MEM -> Mem_Read high 3 cycles, then WB with
//    w_data_s=1; IF-to-IF = 7 cycles.
//  4 BEQ with zf=1 -> PC_Write=1, PC_s=1 in EX. Same with zf=0 -> PC_Write=0.
//    BNE (funct3=001) inverts both cases.
//  5 opcode 7'h7F -> ID then HALT, halted=1; run toggling has no effect;
//    rst_n=0 -> IDLE, halted=0.
//  6 STORE, deassert run in EX and rst_n=0 during MEM stall -> IDLE next cycle,
//    Mem_Write=0. Separately: run=0 in EX with no reset -> store completes, then IDLE.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I subset CPU: sequences IF/ID/EX/MEM/WB,
// decodes the instruction class in ID and stalls in MEM on the data-memory handshake.
module multicycle_ctrl #(
  parameter int unsigned S_W = 3
) (
  input  logic           clk_im,
  input  logic           rst_n,
  input  logic           run,
  input  logic [6:0]     opcode,
  input  logic [2:0]     funct3,
  input  logic           funct7_5,
  input  logic           zf,
  input  logic           mem_ready,
  output logic           PC_Write,
  output logic [1:0]     PC_s,
  output logic           IR_Write,
  output logic           Reg_Write,
  output logic [1:0]     w_data_s,
  output logic           rs2_imm_s,
  output logic [3:0]     ALU_OP,
  output logic           Mem_Read,
  output logic           Mem_Write,
  output logic           halted,
  output logic [S_W-1:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_JAL, C_ILL
  } cls_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  state_t state_q, state_d;
  cls_t   class_q, class_d;
  cls_t   cls_dec;
  logic [3:0] alu_fn;

  // Opcode to instruction class.
  always_comb begin
    cls_dec = C_ILL;
    case (opcode)
      7'b0110011: cls_dec = C_R;
      7'b0010011: cls_dec = C_IALU;
      7'b0000011: cls_dec = C_LOAD;
      7'b0100011: cls_dec = C_STORE;
      7'b1100011: cls_dec = C_BRANCH;
      7'b0110111: cls_dec = C_LUI;
      7'b1101111: cls_dec = C_JAL;
      default:    cls_dec = C_ILL;
    endcase
  end

  // funct7[5] only selects SRA/SRAI among the immediate shifts; R-type always uses it.
  always_comb begin
    alu_fn = {1'b0, funct3};
    if (class_q == C_R) begin
      alu_fn = {funct7_5, funct3};
    end else if (funct3 == 3'b101) begin
      alu_fn = {funct7_5, funct3};
    end
  end

  always_ff @(posedge clk_im) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      class_q <= C_ILL;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
  end

  // Next state and control outputs; only the branch PC_Write depends on inputs.
  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    PC_Write  = 1'b0;
    PC_s      = 2'd0;
    IR_Write  = 1'b0;
    Reg_Write = 1'b0;
    w_data_s  = 2'd0;
    rs2_imm_s = 1'b0;
    ALU_OP    = ALU_ADD;
    Mem_Read  = 1'b0;
    Mem_Write = 1'b0;
    halted    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_IF;
      end
      S_IF: begin
        IR_Write = 1'b1;
        PC_Write = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        class_d = cls_dec;
        case (cls_dec)
          C_ILL:        state_d = S_HALT;
          C_LUI, C_JAL: state_d = S_WB;
          default:      state_d = S_EX;
        endcase
      end
      S_EX: begin
        case (class_q)
          C_R, C_IALU: begin
            ALU_OP    = alu_fn;
            rs2_imm_s = (class_q == C_IALU);
            state_d   = S_WB;
          end
          C_LOAD, C_STORE: begin
            ALU_OP    = ALU_ADD;
            rs2_imm_s = 1'b1;
            state_d   = S_MEM;
          end
          C_BRANCH: begin
            ALU_OP   = ALU_SUB;
            PC_Write = funct3[0] ^ zf;
            PC_s     = 2'd1;
            state_d  = run ? S_IF : S_IDLE;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        rs2_imm_s = 1'b1;
        Mem_Read  = (class_q == C_LOAD);
        Mem_Write = (class_q == C_STORE);
        if (mem_ready) begin
          if (class_q == C_LOAD) state_d = S_WB;
          else                   state_d = run ? S_IF : S_IDLE;
        end
      end
      S_WB: begin
        Reg_Write = 1'b1;
        case (class_q)
          C_LOAD:  w_data_s = 2'd1;
          C_LUI:   w_data_s = 2'd2;
          C_JAL: begin
            w_data_s = 2'd3;
            PC_Write = 1'b1;
            PC_s     = 2'd2;
          end
          default: w_data_s = 2'd0;
        endcase
        state_d = run ? S_IF : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state_o = S_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized
// instruction streams checked cycle by cycle against per-class expected phase sequences.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zf;
  logic       mem_ready;
  logic       PC_Write;
  logic [1:0] PC_s;
  logic       IR_Write;
  logic       Reg_Write;
  logic [1:0] w_data_s;
  logic       rs2_imm_s;
  logic [3:0] ALU_OP;
  logic       Mem_Read;
  logic       Mem_Write;
  logic       halted;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_err    = 0;
  bit in_idle  = 1'b1;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_JAL = 7'b1101111, OP_ILL = 7'h7F;
  localparam logic [14:0] ZERO = 15'd0;

  multicycle_ctrl dut (
    .clk_im(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .zf(zf), .mem_ready(mem_ready), .PC_Write(PC_Write),
    .PC_s(PC_s), .IR_Write(IR_Write), .Reg_Write(Reg_Write), .w_data_s(w_data_s),
    .rs2_imm_s(rs2_imm_s), .ALU_OP(ALU_OP), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .halted(halted), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [14:0] obs;
  assign obs = {PC_Write, PC_s, IR_Write, Reg_Write, w_data_s, rs2_imm_s, ALU_OP,
                Mem_Read, Mem_Write, halted};

  function automatic logic [14:0] mk(input logic pcw, input logic [1:0] pcs, input logic irw,
                                     input logic rw, input logic [1:0] wds, input logic rsi,
                                     input logic [3:0] alu, input logic mr, input logic mw,
                                     input logic h);
    return {pcw, pcs, irw, rw, wds, rsi, alu, mr, mw, h};
  endfunction

  task automatic check(input string tag, input logic [2:0] es, input logic [14:0] ev);
    #1;
    n_checks++;
    assert (state_o === es) else begin
      n_err++;
      $error("FAIL %s state: got %0d expected %0d", tag, state_o, es);
    end
    n_checks++;
    assert (obs === ev) else begin
      n_err++;
      $error("FAIL %s outputs: got %h expected %h", tag, obs, ev);
    end
  endtask

  // One instruction from its IF (or from IDLE) to its last cycle; run_next is the
  // value of run presented at the instruction's closing boundary.
  task automatic do_instr(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                          input logic f75, input logic z, input int unsigned wt,
                          input logic run_next);
    bit is_r, is_i, is_ld, is_st, is_br, is_lui, is_jal;
    logic [3:0] alu;
    is_r = (opc == OP_R);   is_i = (opc == OP_I);     is_ld = (opc == OP_LD);
    is_st = (opc == OP_ST); is_br = (opc == OP_BR);   is_lui = (opc == OP_LUI);
    is_jal = (opc == OP_JAL);
    if (in_idle) begin
      @(negedge clk); run = 1'b1; mem_ready = 1'($urandom);
      check({tag, "/idle"}, 3'd0, ZERO);
    end
    @(negedge clk);
    run = 1'($urandom); opcode = opc; funct3 = f3; funct7_5 = f75;
    zf = 1'($urandom); mem_ready = 1'($urandom);
    check({tag, "/IF"}, 3'd1, mk(1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk); run = 1'($urandom); mem_ready = 1'($urandom);
    check({tag, "/ID"}, 3'd2, ZERO);
    in_idle = !run_next;
    if (!(is_r || is_i || is_ld || is_st || is_br || is_lui || is_jal)) begin
      @(negedge clk); run = 1'($urandom);
      check({tag, "/HALT"}, 3'd6, mk(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
      in_idle = 1'b0;
      return;
    end
    if (!(is_lui || is_jal)) begin
      @(negedge clk); zf = z; mem_ready = 1'($urandom);
      run = is_br ? run_next : 1'($urandom);
      if (is_br) alu = 4'b1000;
      else if (is_r) alu = {f75, f3};
      else if (is_i) alu = (f3 == 3'd5) ? {f75, f3} : {1'b0, f3};
      else alu = 4'b0000;
      if (is_br)
        check({tag, "/EX"}, 3'd3, mk(f3[0] ^ z, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, alu, 1'b0, 1'b0, 1'b0));
      else
        check({tag, "/EX"}, 3'd3, mk(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, (is_i || is_ld || is_st), alu,
                                     1'b0, 1'b0, 1'b0));
    end
    if (is_br) return;
    if (is_ld || is_st) begin
      for (int i = 0; i <= int'(wt); i++) begin
        @(negedge clk); zf = 1'($urandom);
        mem_ready = (i == int'(wt));
        run = (is_st && i == int'(wt)) ? run_next : 1'($urandom);
        check({tag, "/MEM"}, 3'd4, mk(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 4'd0, is_ld, is_st, 1'b0));
      end
    end
    if (is_st) return;
    @(negedge clk); run = run_next; mem_ready = 1'($urandom);
    if (is_jal)
      check({tag, "/WB"}, 3'd5, mk(1'b1, 2'd2, 1'b0, 1'b1, 2'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    else
      check({tag, "/WB"}, 3'd5, mk(1'b0, 2'd0, 1'b0, 1'b1, is_ld ? 2'd1 : (is_lui ? 2'd2 : 2'd0),
                                   1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
  endtask

  logic [6:0] ops [7];

  initial begin
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD; ops[3] = OP_ST;
    ops[4] = OP_BR; ops[5] = OP_LUI; ops[6] = OP_JAL;
    rst_n = 1'b0; run = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    zf = 1'b0; mem_ready = 1'b0;

    // Reset held two cycles, then idle with run low.
    @(negedge clk); check("rst1", 3'd0, ZERO);
    @(negedge clk); check("rst2", 3'd0, ZERO);
    rst_n = 1'b1;
    @(negedge clk); run = 1'b0; check("idle_run0", 3'd0, ZERO);
    in_idle = 1'b1;

    // add x0, x1, x2 (0x00208033)
    do_instr("add", OP_R, 3'd0, 1'b0, 1'b0, 0, 1'b1);
    do_instr("sra", OP_R, 3'd5, 1'b1, 1'b0, 0, 1'b1);
    do_instr("srai", OP_I, 3'd5, 1'b1, 1'b0, 0, 1'b1);
    do_instr("addi_f7", OP_I, 3'd0, 1'b1, 1'b0, 0, 1'b1);
    do_instr("load_w2", OP_LD, 3'd2, 1'b0, 1'b0, 2, 1'b1);
    do_instr("beq_z1", OP_BR, 3'd0, 1'b0, 1'b1, 0, 1'b1);
    do_instr("beq_z0", OP_BR, 3'd0, 1'b0, 1'b0, 0, 1'b1);
    do_instr("bne_z1", OP_BR, 3'd1, 1'b0, 1'b1, 0, 1'b1);
    do_instr("bne_z0", OP_BR, 3'd1, 1'b0, 1'b0, 0, 1'b1);
    do_instr("lui", OP_LUI, 3'd3, 1'b1, 1'b0, 0, 1'b1);
    do_instr("jal", OP_JAL, 3'd7, 1'b0, 1'b0, 0, 1'b1);
    do_instr("store_stop", OP_ST, 3'd2, 1'b0, 1'b0, 1, 1'b0);
    @(negedge clk); run = 1'b0; check("after_store_idle", 3'd0, ZERO);

    // Random instruction stream with random waits and run drops at boundaries.
    for (int k = 0; k < 80; k++) begin
      do_instr("rand", ops[$urandom_range(6, 0)], 3'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(3, 0), ($urandom_range(3, 0) != 0));
    end

    // Store stalled in MEM with run dropped in EX, then reset mid-stall.
    if (!in_idle) begin
      do_instr("pre_st", OP_R, 3'd0, 1'b0, 1'b0, 0, 1'b0);
    end
    @(negedge clk); run = 1'b1; check("st_rst/idle", 3'd0, ZERO);
    @(negedge clk); opcode = OP_ST; funct3 = 3'd2; funct7_5 = 1'b0; mem_ready = 1'b0;
    check("st_rst/IF", 3'd1, mk(1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk); check("st_rst/ID", 3'd2, ZERO);
    @(negedge clk); run = 1'b0;
    check("st_rst/EX", 3'd3, mk(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check("st_rst/MEM1", 3'd4, mk(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0));
    @(negedge clk); rst_n = 1'b0;
    check("st_rst/MEM2", 3'd4, mk(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0));
    @(negedge clk); mem_ready = 1'b1; check("st_rst/after", 3'd0, ZERO);
    rst_n = 1'b1;
    @(negedge clk); mem_ready = 1'b0; check("st_rst/idle2", 3'd0, ZERO);
    in_idle = 1'b1;

    // Illegal opcode halts; run has no effect until reset.
    do_instr("ill", OP_ILL, 3'd0, 1'b0, 1'b0, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); run = 1'(k); mem_ready = 1'($urandom);
      check("halt_hold", 3'd6, mk(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
    end
    @(negedge clk); rst_n = 1'b0; run = 1'b1;
    check("halt_rst", 3'd6, mk(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
    @(negedge clk); run = 1'b0; check("halt_cleared", 3'd0, ZERO);
    rst_n = 1'b1;
    @(negedge clk); check("final_idle", 3'd0, ZERO);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
